// File: rtl/irq_pkg.sv
// Shared constants and FSM state type for the eight-source interrupt controller.
package irq_pkg;

   localparam int NUM_SRC = 8;
   localparam int ID_W    = 3;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2
   } irq_state_t;

endpackage

// File: rtl/prio_enc8.sv
// Combinational 8-to-3 priority encoder: the highest set index wins, valid flags any request.
module prio_enc8
   import irq_pkg::*;
(
   input  logic [NUM_SRC-1:0] req,
   output logic [ID_W-1:0]    id,
   output logic               valid
);

   // NOTE: every output gets a default before the loop, otherwise a combinational block infers latches.
   always_comb begin
      id    = '0;
      valid = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (req[i]) begin
            id    = ID_W'(i);
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/irq_ctrl8.sv
// Interrupt controller: synchronises sources, tracks pending state and runs the req/ack/eoi handshake.
module irq_ctrl8
   import irq_pkg::*;
#(
   parameter logic [NUM_SRC-1:0] EDGE_MODE   = 8'hFF,
   parameter int                 SYNC_STAGES = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_SRC-1:0] irq_src,
   input  logic [NUM_SRC-1:0] irq_en,
   input  logic               irq_ack,
   input  logic               irq_eoi,
   output logic               irq_req,
   output logic [ID_W-1:0]    irq_id,
   output logic               irq_busy,
   output logic [NUM_SRC-1:0] pending
);

   logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
   logic [NUM_SRC-1:0] s, s_d;
   logic [NUM_SRC-1:0] cand, clr_mask, pend_nxt;
   logic [ID_W-1:0]    enc_id, id_nxt;
   logic               enc_valid, accept;
   irq_state_t         state, state_nxt;

   assign s = sync_q[SYNC_STAGES-1];

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
         s_d <= '0;
      end else begin
         sync_q[0] <= irq_src;
         for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
         s_d <= s;
      end
   end

   assign cand = pending & irq_en;

   prio_enc8 u_enc (
      .req   (cand),
      .id    (enc_id),
      .valid (enc_valid)
   );

   always_comb begin
      state_nxt = state;
      id_nxt    = irq_id;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            if (enc_valid) begin
               state_nxt = REQ;
               id_nxt    = enc_id;
            end
         end
         REQ: begin
            // Ack takes precedence over a withdraw seen in the same cycle.
            if (irq_ack) begin
               state_nxt = SERVICE;
               accept    = 1'b1;
            end else if (!cand[irq_id]) begin
               state_nxt = IDLE;
            end
         end
         SERVICE: begin
            if (irq_eoi) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Edge bits: a new rising edge beats the accept-clear; level bits just mirror the synchronised line.
   always_comb begin
      clr_mask = '0;
      if (accept) clr_mask[irq_id] = 1'b1;
      pend_nxt = (EDGE_MODE & ((pending & ~clr_mask) | (s & ~s_d))) | (~EDGE_MODE & s);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         irq_id   <= '0;
         irq_req  <= 1'b0;
         irq_busy <= 1'b0;
         pending  <= '0;
      end else begin
         state    <= state_nxt;
         irq_id   <= id_nxt;
         irq_req  <= (state_nxt == REQ);
         irq_busy <= (state_nxt == SERVICE);
         pending  <= pend_nxt;
      end
   end

endmodule

// File: tb/tb_irq_ctrl8.sv
// Self-checking bench for irq_ctrl8: directed table, corner sequences and randomized run against a model.
module tb_irq_ctrl8;

   localparam int         SYNC = 2;
   localparam logic [7:0] EDGE = 8'hFE;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] irq_src = '0;
   logic [7:0] irq_en = 8'hFF;
   logic       irq_ack = 1'b0;
   logic       irq_eoi = 1'b0;
   logic       irq_req;
   logic [2:0] irq_id;
   logic       irq_busy;
   logic [7:0] pending;

   int n_tests = 0;
   int n_fail  = 0;

   irq_ctrl8 #(.EDGE_MODE(EDGE), .SYNC_STAGES(SYNC)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .irq_src  (irq_src),
      .irq_en   (irq_en),
      .irq_ack  (irq_ack),
      .irq_eoi  (irq_eoi),
      .irq_req  (irq_req),
      .irq_id   (irq_id),
      .irq_busy (irq_busy),
      .pending  (pending)
   );

   always #5 clk = ~clk;

   // Reference model: samples history queue, pending bits, and two flags for presenting/serving.
   logic [7:0] m_hist [$];
   logic [7:0] m_pend;
   logic       m_presenting, m_serving;
   logic [2:0] m_id;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_hist = {};
      for (int i = 0; i <= SYNC; i++) m_hist.push_back(8'h00);
      m_pend       = '0;
      m_presenting = 1'b0;
      m_serving    = 1'b0;
      m_id         = '0;
   endtask

   function automatic int highest(input logic [7:0] v);
      for (int i = 7; i >= 0; i--) if (v[i]) return i;
      return -1;
   endfunction

   task automatic model_step();
      logic [7:0] s, sd, cand, clr, np;
      s    = m_hist[SYNC-1];
      sd   = m_hist[SYNC];
      cand = m_pend & irq_en;
      clr  = '0;
      if (m_serving) begin
         if (irq_eoi) m_serving = 1'b0;
      end else if (m_presenting) begin
         if (irq_ack) begin
            m_presenting = 1'b0;
            m_serving    = 1'b1;
            clr[m_id]    = 1'b1;
         end else if (!cand[m_id]) begin
            m_presenting = 1'b0;
         end
      end else if (cand != 0) begin
         m_presenting = 1'b1;
         m_id         = 3'(highest(cand));
      end
      for (int i = 0; i < 8; i++)
         np[i] = EDGE[i] ? ((m_pend[i] && !clr[i]) || (s[i] && !sd[i])) : s[i];
      m_pend = np;
      m_hist.push_front(irq_src);
      void'(m_hist.pop_back());
   endtask

   task automatic check_model();
      check("model_req",  8'(irq_req),  8'(m_presenting));
      check("model_busy", 8'(irq_busy), 8'(m_serving));
      check("model_id",   8'(irq_id),   8'(m_id));
      check("model_pend", pending,      m_pend);
   endtask

   // Called at a negedge: drive, advance one edge, compare at the following negedge.
   task automatic step(input logic [7:0] s, input logic [7:0] e, input logic a, input logic o);
      irq_src = s;
      irq_en  = e;
      irq_ack = a;
      irq_eoi = o;
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_model();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      model_reset();
      check("rst_req",  8'(irq_req),  8'h00);
      check("rst_id",   8'(irq_id),   8'h00);
      check("rst_busy", 8'(irq_busy), 8'h00);
      check("rst_pend", pending,      8'h00);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   typedef struct {
      logic [7:0] src;
      logic [7:0] en;
      logic       ack;
      logic       eoi;
      logic       req;
      logic [2:0] id;
      logic       busy;
      logic [7:0] pend;
   } vec_t;

   vec_t tbl [15];

   initial begin
      tbl[0]  = '{8'h08, 8'hFF, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00};
      tbl[1]  = '{8'h08, 8'hFF, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00};
      tbl[2]  = '{8'h08, 8'hFF, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'h08};
      tbl[3]  = '{8'h08, 8'hFF, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 8'h08};
      tbl[4]  = '{8'h00, 8'hFF, 1'b1, 1'b0, 1'b0, 3'd3, 1'b1, 8'h00};
      tbl[5]  = '{8'h00, 8'hFF, 1'b0, 1'b0, 1'b0, 3'd3, 1'b1, 8'h00};
      tbl[6]  = '{8'h00, 8'hFF, 1'b0, 1'b1, 1'b0, 3'd3, 1'b0, 8'h00};
      tbl[7]  = '{8'h00, 8'hFF, 1'b1, 1'b0, 1'b0, 3'd3, 1'b0, 8'h00};
      tbl[8]  = '{8'h08, 8'hF7, 1'b0, 1'b1, 1'b0, 3'd3, 1'b0, 8'h00};
      tbl[9]  = '{8'h08, 8'hF7, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 8'h00};
      tbl[10] = '{8'h08, 8'hF7, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 8'h08};
      tbl[11] = '{8'h00, 8'hF7, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 8'h08};
      tbl[12] = '{8'h00, 8'hFF, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 8'h08};
      tbl[13] = '{8'h00, 8'hFF, 1'b1, 1'b0, 1'b0, 3'd3, 1'b1, 8'h00};
      tbl[14] = '{8'h00, 8'hFF, 1'b0, 1'b1, 1'b0, 3'd3, 1'b0, 8'h00};

      model_reset();
      repeat (2) @(negedge clk);
      do_reset();

      // Directed table: edge source 3 end to end, then masked pending and unmask.
      for (int k = 0; k < 15; k++) begin
         step(tbl[k].src, tbl[k].en, tbl[k].ack, tbl[k].eoi);
         check($sformatf("tbl%0d_req", k),  8'(irq_req),  8'(tbl[k].req));
         check($sformatf("tbl%0d_id", k),   8'(irq_id),   8'(tbl[k].id));
         check($sformatf("tbl%0d_busy", k), 8'(irq_busy), 8'(tbl[k].busy));
         check($sformatf("tbl%0d_pend", k), pending,      tbl[k].pend);
      end

      // Sources 1 and 6 together: 6 first, then 1 after eoi.
      repeat (4) step(8'h42, 8'hFF, 1'b0, 1'b0);
      check("pair_req6", 8'(irq_req), 8'h01);
      check("pair_id6",  8'(irq_id),  8'h06);
      step(8'h00, 8'hFF, 1'b1, 1'b0);
      check("pair_busy", 8'(irq_busy), 8'h01);
      check("pair_pend", pending,      8'h02);
      step(8'h00, 8'hFF, 1'b0, 1'b1);
      check("pair_eoi_busy", 8'(irq_busy), 8'h00);
      step(8'h00, 8'hFF, 1'b0, 1'b0);
      check("pair_req1", 8'(irq_req), 8'h01);
      check("pair_id1",  8'(irq_id),  8'h01);
      step(8'h00, 8'hFF, 1'b1, 1'b0);
      step(8'h00, 8'hFF, 1'b0, 1'b1);

      // Withdraw on mask, re-present, then ack beats withdraw.
      repeat (4) step(8'h20, 8'hFF, 1'b0, 1'b0);
      check("wd_req", 8'(irq_req), 8'h01);
      check("wd_id",  8'(irq_id),  8'h05);
      step(8'h00, 8'hDF, 1'b0, 1'b0);
      check("wd_gone",  8'(irq_req), 8'h00);
      check("wd_pend",  pending,     8'h20);
      step(8'h00, 8'hFF, 1'b0, 1'b0);
      check("wd_again", 8'(irq_req), 8'h01);
      step(8'h00, 8'hDF, 1'b1, 1'b0);
      check("wd_ack_busy", 8'(irq_busy), 8'h01);
      check("wd_ack_req",  8'(irq_req),  8'h00);
      check("wd_ack_pend", pending,      8'h00);
      step(8'h00, 8'hFF, 1'b0, 1'b1);

      // Source 2 re-edges in the accept cycle: pending survives, re-presented after eoi.
      step(8'h04, 8'hFF, 1'b0, 1'b0);
      step(8'h04, 8'hFF, 1'b0, 1'b0);
      step(8'h00, 8'hFF, 1'b0, 1'b0);
      step(8'h04, 8'hFF, 1'b0, 1'b0);
      check("re_req", 8'(irq_req), 8'h01);
      check("re_id",  8'(irq_id),  8'h02);
      step(8'h04, 8'hFF, 1'b0, 1'b0);
      step(8'h00, 8'hFF, 1'b1, 1'b0);
      check("re_busy", 8'(irq_busy), 8'h01);
      check("re_pend", pending,      8'h04);
      step(8'h00, 8'hFF, 1'b0, 1'b1);
      step(8'h00, 8'hFF, 1'b0, 1'b0);
      check("re_again", 8'(irq_req), 8'h01);
      check("re_again_id", 8'(irq_id), 8'h02);
      step(8'h00, 8'hFF, 1'b1, 1'b0);
      step(8'h00, 8'hFF, 1'b0, 1'b1);

      // Level source 0 held high through eoi is re-presented; reset mid-service clears all.
      repeat (4) step(8'h01, 8'hFF, 1'b0, 1'b0);
      check("lvl_req", 8'(irq_req), 8'h01);
      check("lvl_id",  8'(irq_id),  8'h00);
      step(8'h01, 8'hFF, 1'b1, 1'b0);
      check("lvl_pend_kept", pending, 8'h01);
      step(8'h01, 8'hFF, 1'b0, 1'b1);
      step(8'h01, 8'hFF, 1'b0, 1'b0);
      check("lvl_again", 8'(irq_req), 8'h01);
      step(8'h01, 8'hFF, 1'b1, 1'b0);
      check("lvl_busy", 8'(irq_busy), 8'h01);
      do_reset();

      // Randomized traffic against the model, with occasional resets.
      irq_src = '0;
      for (int c = 0; c < 3000; c++) begin
         logic [7:0] ns, ne;
         ns = irq_src;
         for (int b = 0; b < 8; b++) if ($urandom_range(0, 7) == 0) ns[b] = ~ns[b];
         ne = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
         step(ns, ne, ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0));
         if ($urandom_range(0, 499) == 0) do_reset();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
